ghash_core: RTL and testbench
=============================

// Module: ghash_core
// PURPOSE
//  Sequential GHASH engine for AES-GCM. It absorbs AAD blocks, then ciphertext blocks, then appends the length block.
//  Per block it computes Y <= (Y ^ X) * H, using one gfmul instance, and returns the 128-bit GHASH for tag generation.
//  Upstream is the AES-CTR datapath, which supplies ciphertext. Downstream, the tag XOR consumes oGhash ^ E(K,J0).
// PARAMETERS
//  LEN_W    36  byte-counter width per phase. GCM max is 2^36-32 bytes. Bit length is {cnt,3'b000}, zero-extended to 64.
//  REG_OPND 1   1: register (Y^X) before gfmul, 2 cycles/block. 0: gfmul fed directly from logic, 1 cycle/block.
// PORTS
//  iClk        in   1       clock
//  iRst        in   1       async reset, active-high
//  iStart      in   1       pulse: latch iHashkey, clear Y/counters/error, enter ACCEPT
//  iHashkey    in   [0:127] H = E(K,0^128), sampled only when iStart=1
//  iBlkValid   in   1       block handshake valid
//  oBlkReady   out  1       block handshake ready
//  iBlk        in   [0:127] data block, byte 0 = bits [0:7]
//  iBlkBytes   in   5       valid bytes, 1..16; bytes >= iBlkBytes are forced to zero
//  iBlkIsAad   in   1       1 = AAD block, 0 = ciphertext block
//  iFinal      in   1       pulse, only with iBlkValid=0: no more data; hash length block and finish
//  oGhash      out  [0:127] final GHASH, held until next iStart
//  oDone       out  1       1-cycle pulse when oGhash is valid
//  oBusy       out  1       high from iStart until oDone
//  oErr        out  1       sticky protocol error, cleared by iStart
// BEHAVIOUR
//  Reset: state=IDLE, Y=0, H=0, counters=0. oGhash=0, oDone=0, oBusy=0, oErr=0, oBlkReady=0.
//  FSM states: IDLE, ACCEPT, MUL, LEN, LENMUL, DONE.
//   IDLE:   iStart -> ACCEPT. Other inputs ignored.
//   ACCEPT: oBlkReady=1. Transfer when iBlkValid & oBlkReady.
//           On transfer: X = padded iBlk; add iBlkBytes to the AAD or CT byte counter.
//           If REG_OPND=1, go to MUL. If REG_OPND=0, Y <= (Y^X)*H in the same cycle and stay in ACCEPT.
//           iFinal -> LEN.
//   MUL:    oBlkReady=0; Y <= gfmul(opnd, H) -> ACCEPT.
//   LEN:    X = {64'(aad_bytes*8), 64'(ct_bytes*8)}; same xor/multiply path -> LENMUL (or DONE if REG_OPND=0).
//   LENMUL: Y <= gfmul(opnd, H) -> DONE.
//   DONE:   oGhash <= Y, oDone=1 for 1 cycle -> IDLE.
//  Latency: iFinal to oDone = 3 cycles (REG_OPND=1) or 2 cycles (REG_OPND=0).
//  Ordering rules. Each violation sets oErr; the block is still hashed and the FSM continues:
//   - an AAD block after any CT block;
//   - any block of a phase after a partial (<16 byte) block of that phase;
//   - iBlkBytes==0 or >16. Such a block is treated as 16 bytes.
//  iBlkValid and iFinal asserted together: the block is taken, iFinal is ignored, and oErr is set.
//  iStart in any non-IDLE state aborts the current hash, restarts (H reloaded, Y=0), and causes no oDone.
//  Counter overflow at 2^LEN_W wraps and sets oErr.
//  Empty AAD and empty CT (iFinal straight after iStart): length block = 0, so GHASH = 0.
//  Async reset mid-hash returns to the reset state immediately. No oDone.
// STRUCTURE
//  Shared package gcm_pkg: BLK_W=128, GHASH_R = 128'hE1<<120, the state enum,
//  and the function pad_blk(blk, nbytes).
//  Sub-module: the existing gfmul (iCtext=opnd, iHashkey=H, oResult), instantiated once.
//  Remaining logic (FSM, counters, padding, length block) lives in ghash_core.
// TESTING
//  T1 iStart, H=any, then iFinal -> oDone after 3 cycles; oGhash=0, oErr=0.
//  T2 H=128'h8000..0 (identity). AAD 16B blk A, CT 16B blk C, iFinal.
//     Expect oGhash = A ^ C ^ {64'd128, 64'd128}.
//  T3 H=identity. CT 5B blk 0xFFFF..FF.
//     Expect oGhash = 128'hFFFFFFFFFF<<88 ^ {64'd0, 64'd40}; confirms padding.
//  T4 H=0x66e94bd4ef8a2c3b884cfa59ca342b2e, 3 AAD + 4 CT random blocks with oBlkReady backpressure.
//     oGhash must match the software GHASH model bit-exactly.
//  T5 CT block, then AAD block -> oErr=1, stays 1 until next iStart.
//     Also: AAD 7B, then AAD 16B -> oErr=1.
//  T6 iStart mid-MUL with new H -> no oDone for the aborted hash.
//     Async iRst mid-ACCEPT -> all outputs 0 immediately.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared GCM definitions: block width, GHASH reduction constant, engine states
// and the byte-padding helpers used on incoming blocks.
package gcm_pkg;

    localparam int BLK_W = 128;
    localparam logic [0:BLK_W-1] GHASH_R = 128'hE1 << 120;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        MUL,
        LEN,
        LENMUL,
        DONE
    } state_t;

    // Out-of-range byte counts are treated as a full block.
    function automatic logic [4:0] eff_bytes(input logic [4:0] nbytes);
        return (nbytes == 5'd0 || nbytes > 5'd16) ? 5'd16 : nbytes;
    endfunction

    function automatic logic [0:BLK_W-1] pad_blk(input logic [0:BLK_W-1] blk,
                                                 input logic [4:0]       nbytes);
        logic [0:BLK_W-1] r;
        logic [4:0]       n;
        r = blk;
        n = eff_bytes(nbytes);
        for (int k = 0; k < 16; k++) begin
            if (5'(k) >= n) r[8*k +: 8] = 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/gfmul.sv
// Combinational GF(2^128) multiplier in GCM bit order (index 0 = x^0).
module gfmul
    import gcm_pkg::*;
(
    input  logic [0:BLK_W-1] iCtext,
    input  logic [0:BLK_W-1] iHashkey,
    output logic [0:BLK_W-1] oResult
);

    logic [0:BLK_W-1] w_z;
    logic [0:BLK_W-1] w_v;

    always_comb begin
        w_z = '0;
        w_v = iHashkey;
        for (int i = 0; i < BLK_W; i++) begin
            if (iCtext[i]) w_z = w_z ^ w_v;
            w_v = w_v[BLK_W-1] ? ((w_v >> 1) ^ GHASH_R) : (w_v >> 1);
        end
        oResult = w_z;
    end

endmodule

// File: rtl/ghash_core.sv
// Sequential GHASH engine: absorbs AAD then ciphertext blocks, appends the
// length block and reports Y for tag generation. One shared gfmul instance.
module ghash_core
    import gcm_pkg::*;
#(
    parameter int LEN_W    = 36,
    parameter int REG_OPND = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [0:BLK_W-1] iHashkey,
    input  logic             iBlkValid,
    output logic             oBlkReady,
    input  logic [0:BLK_W-1] iBlk,
    input  logic [4:0]       iBlkBytes,
    input  logic             iBlkIsAad,
    input  logic             iFinal,
    output logic [0:BLK_W-1] oGhash,
    output logic             oDone,
    output logic             oBusy,
    output logic             oErr
);

    state_t           r_state;
    logic [0:BLK_W-1] r_h;
    logic [0:BLK_W-1] r_y;
    logic [0:BLK_W-1] r_opnd;
    logic [0:BLK_W-1] r_ghash;
    logic [LEN_W-1:0] r_aad_cnt;
    logic [LEN_W-1:0] r_ct_cnt;
    logic             r_seen_ct;
    logic             r_aad_part;
    logic             r_ct_part;
    logic             r_err;
    logic             r_done;
    logic             r_busy;
    logic             r_ready;

    logic [4:0]       w_nb;
    logic [0:BLK_W-1] w_blk;
    logic [0:BLK_W-1] w_len_blk;
    logic [0:BLK_W-1] w_x;
    logic [0:BLK_W-1] w_opnd;
    logic [0:BLK_W-1] w_mul_in;
    logic [0:BLK_W-1] w_prod;
    logic [LEN_W:0]   w_aad_sum;
    logic [LEN_W:0]   w_ct_sum;
    logic             w_blk_err;

    assign w_nb      = eff_bytes(iBlkBytes);
    assign w_blk     = pad_blk(iBlk, iBlkBytes);
    assign w_len_blk = {{(61-LEN_W){1'b0}}, r_aad_cnt, 3'b000,
                        {(61-LEN_W){1'b0}}, r_ct_cnt, 3'b000};
    assign w_x       = (r_state == LEN) ? w_len_blk : w_blk;
    assign w_opnd    = r_y ^ w_x;
    assign w_mul_in  = (REG_OPND != 0) ? r_opnd : w_opnd;

    assign w_aad_sum = {1'b0, r_aad_cnt} + (LEN_W+1)'(w_nb);
    assign w_ct_sum  = {1'b0, r_ct_cnt} + (LEN_W+1)'(w_nb);

    // Ordering, size, overflow and valid-with-final violations; block is still hashed.
    assign w_blk_err = (iBlkIsAad & (r_seen_ct | r_aad_part))
                     | (~iBlkIsAad & r_ct_part)
                     | (iBlkBytes == 5'd0) | (iBlkBytes > 5'd16)
                     | iFinal
                     | (iBlkIsAad ? w_aad_sum[LEN_W] : w_ct_sum[LEN_W]);

    gfmul u_gfmul (
        .iCtext  (w_mul_in),
        .iHashkey(r_h),
        .oResult (w_prod)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= IDLE;
            r_h        <= '0;
            r_y        <= '0;
            r_opnd     <= '0;
            r_ghash    <= '0;
            r_aad_cnt  <= '0;
            r_ct_cnt   <= '0;
            r_seen_ct  <= 1'b0;
            r_aad_part <= 1'b0;
            r_ct_part  <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (iStart) begin
                r_h        <= iHashkey;
                r_y        <= '0;
                r_aad_cnt  <= '0;
                r_ct_cnt   <= '0;
                r_seen_ct  <= 1'b0;
                r_aad_part <= 1'b0;
                r_ct_part  <= 1'b0;
                r_err      <= 1'b0;
                r_busy     <= 1'b1;
                r_ready    <= 1'b1;
                r_state    <= ACCEPT;
            end else begin
                case (r_state)
                    ACCEPT: begin
                        if (iBlkValid) begin
                            if (iBlkIsAad) begin
                                r_aad_cnt <= w_aad_sum[LEN_W-1:0];
                                if (w_nb != 5'd16) r_aad_part <= 1'b1;
                            end else begin
                                r_ct_cnt  <= w_ct_sum[LEN_W-1:0];
                                r_seen_ct <= 1'b1;
                                if (w_nb != 5'd16) r_ct_part <= 1'b1;
                            end
                            if (w_blk_err) r_err <= 1'b1;
                            if (REG_OPND != 0) begin
                                r_opnd  <= w_opnd;
                                r_ready <= 1'b0;
                                r_state <= MUL;
                            end else begin
                                r_y <= w_prod;
                            end
                        end else if (iFinal) begin
                            r_ready <= 1'b0;
                            r_state <= LEN;
                        end
                    end
                    MUL: begin
                        r_y     <= w_prod;
                        r_ready <= 1'b1;
                        r_state <= ACCEPT;
                    end
                    LEN: begin
                        if (REG_OPND != 0) begin
                            r_opnd  <= w_opnd;
                            r_state <= LENMUL;
                        end else begin
                            r_y     <= w_prod;
                            r_state <= DONE;
                        end
                    end
                    LENMUL: begin
                        r_y     <= w_prod;
                        r_state <= DONE;
                    end
                    DONE: begin
                        r_ghash <= r_y;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_ready <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign oBlkReady = r_ready;
    assign oGhash    = r_ghash;
    assign oDone     = r_done;
    assign oBusy     = r_busy;
    assign oErr      = r_err;

endmodule

// File: tb/tb_ghash_core.sv
// Directed + randomized bench for ghash_core with a polynomial-arithmetic GHASH model.
module tb_ghash_core;

    logic         clk = 1'b0;
    logic         iRst;
    logic         iStart;
    logic [0:127] iHashkey;
    logic         iBlkValid;
    logic         oBlkReady;
    logic [0:127] iBlk;
    logic [4:0]   iBlkBytes;
    logic         iBlkIsAad;
    logic         iFinal;
    logic [0:127] oGhash;
    logic         oDone;
    logic         oBusy;
    logic         oErr;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;

    logic [127:0] m_y, m_h;
    longint       m_aad, m_ct;

    always #5 clk = ~clk;

    always @(negedge clk) if (oDone) done_cnt++;

    ghash_core dut (
        .iClk     (clk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iHashkey (iHashkey),
        .iBlkValid(iBlkValid),
        .oBlkReady(oBlkReady),
        .iBlk     (iBlk),
        .iBlkBytes(iBlkBytes),
        .iBlkIsAad(iBlkIsAad),
        .iFinal   (iFinal),
        .oGhash   (oGhash),
        .oDone    (oDone),
        .oBusy    (oBusy),
        .oErr     (oErr)
    );

    // Value bit 127 is GCM bit 0, i.e. the x^0 coefficient.
    function automatic logic [127:0] rev128(input logic [127:0] a);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) r[i] = a[127-i];
        return r;
    endfunction

    // Carry-less product, then reduction modulo x^128 + x^7 + x^2 + x + 1.
    function automatic logic [127:0] gcm_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] ar, br;
        logic [254:0] p;
        ar = rev128(a);
        br = rev128(b);
        p  = '0;
        for (int i = 0; i < 128; i++) if (br[i]) p = p ^ (255'(ar) << i);
        for (int i = 254; i >= 128; i--) begin
            if (p[i]) begin
                p[i]     = 1'b0;
                p[i-121] = ~p[i-121];
                p[i-126] = ~p[i-126];
                p[i-127] = ~p[i-127];
                p[i-128] = ~p[i-128];
            end
        end
        return rev128(p[127:0]);
    endfunction

    function automatic logic [127:0] model_result();
        logic [127:0] lenblk;
        lenblk = {64'(m_aad * 8), 64'(m_ct * 8)};
        return gcm_mul(m_y ^ lenblk, m_h);
    endfunction

    task automatic absorb(input logic [127:0] blk, input int nb, input bit aad);
        int e;
        logic [127:0] mask;
        e    = (nb == 0 || nb > 16) ? 16 : nb;
        mask = (e == 16) ? {128{1'b1}} : ~({128{1'b1}} >> (8 * e));
        m_y  = gcm_mul(m_y ^ (blk & mask), m_h);
        if (aad) m_aad += e; else m_ct += e;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic start(input logic [127:0] h);
        iStart   = 1'b1;
        iHashkey = h;
        @(negedge clk);
        iStart = 1'b0;
        m_y = '0; m_h = h; m_aad = 0; m_ct = 0;
    endtask

    task automatic send(input logic [127:0] blk, input int nb, input bit aad, input bit fin);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        iBlk      = blk;
        iBlkBytes = 5'(nb);
        iBlkIsAad = aad;
        iFinal    = fin;
        iBlkValid = 1'b1;
        n = 0;
        while (!oBlkReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        iBlkValid = 1'b0;
        iFinal    = 1'b0;
        absorb(blk, nb, aad);
    endtask

    task automatic finish_hash(input string tag, input logic [127:0] exp, input bit exp_err);
        int n;
        int lat;
        n = 0;
        while (!oBlkReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        iFinal = 1'b1;
        @(negedge clk);
        iFinal = 1'b0;
        lat = 0;
        while (!oDone && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd3);
        chk({tag, "_ghash"}, oGhash, exp);
        chk({tag, "_err"}, oErr, exp_err);
        chk({tag, "_busy"}, oBusy, 1'b0);
    endtask

    initial begin
        logic [127:0] a, c, h, exp;
        int d0, na, nc;

        iRst = 1'b1; iStart = 1'b0; iHashkey = '0; iBlkValid = 1'b0;
        iBlk = '0; iBlkBytes = 5'd0; iBlkIsAad = 1'b0; iFinal = 1'b0;
        m_y = '0; m_h = '0; m_aad = 0; m_ct = 0;
        #12;
        chk("rst_ghash", oGhash, 128'd0);
        chk("rst_done", oDone, 1'b0);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_err", oErr, 1'b0);
        chk("rst_ready", oBlkReady, 1'b0);
        @(negedge clk);
        iRst = 1'b0;

        // T1: empty message hashes to zero
        start({$urandom, $urandom, $urandom, $urandom});
        chk("t1_busy", oBusy, 1'b1);
        chk("t1_ready", oBlkReady, 1'b1);
        finish_hash("t1", 128'd0, 1'b0);

        // T2: identity key, one AAD and one CT block
        a = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom};
        start(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send(a, 16, 1'b1, 1'b0);
        send(c, 16, 1'b0, 1'b0);
        exp = a ^ c ^ {64'd128, 64'd128};
        finish_hash("t2", exp, 1'b0);

        // T3: padding of a 5-byte CT block
        start(128'h8000_0000_0000_0000_0000_0000_0000_0000);
        send({128{1'b1}}, 5, 1'b0, 1'b0);
        exp = (128'hFFFFFFFFFF << 88) ^ {64'd0, 64'd40};
        finish_hash("t3", exp, 1'b0);

        // T4: reference key, 3 AAD + 4 CT random blocks, partial tails
        start(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        for (int i = 0; i < 3; i++)
            send({$urandom, $urandom, $urandom, $urandom},
                 (i == 2) ? int'($urandom_range(1, 16)) : 16, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom, $urandom, $urandom},
                 (i == 3) ? int'($urandom_range(1, 16)) : 16, 1'b0, 1'b0);
        finish_hash("t4", model_result(), 1'b0);

        // Random well-formed messages
        for (int r = 0; r < 3; r++) begin
            h = {$urandom, $urandom, $urandom, $urandom};
            start(h);
            na = $urandom_range(0, 3);
            nc = $urandom_range(0, 4);
            for (int i = 0; i < na; i++)
                send({$urandom, $urandom, $urandom, $urandom},
                     (i == na - 1) ? int'($urandom_range(1, 16)) : 16, 1'b1, 1'b0);
            for (int i = 0; i < nc; i++)
                send({$urandom, $urandom, $urandom, $urandom},
                     (i == nc - 1) ? int'($urandom_range(1, 16)) : 16, 1'b0, 1'b0);
            finish_hash($sformatf("rnd%0d", r), model_result(), 1'b0);
        end

        // T5: ordering errors are sticky but blocks are still hashed
        start({$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b0);
        chk("t5_ct_first_err", oErr, 1'b0);
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b1, 1'b0);
        chk("t5_aad_after_ct", oErr, 1'b1);
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b0);
        chk("t5_sticky", oErr, 1'b1);
        finish_hash("t5a", model_result(), 1'b1);
        start({$urandom, $urandom, $urandom, $urandom});
        chk("t5_start_clears", oErr, 1'b0);
        send({$urandom, $urandom, $urandom, $urandom}, 7, 1'b1, 1'b0);
        chk("t5_partial_ok", oErr, 1'b0);
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b1, 1'b0);
        chk("t5_after_partial", oErr, 1'b1);
        finish_hash("t5b", model_result(), 1'b1);

        // Zero byte count is hashed as a full block and flagged
        start({$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0);
        chk("bytes0_err", oErr, 1'b1);
        finish_hash("bytes0", model_result(), 1'b1);

        // Valid together with final: block taken, final ignored
        start({$urandom, $urandom, $urandom, $urandom});
        d0 = done_cnt;
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("vf_err", oErr, 1'b1);
        chk("vf_no_done", 128'(done_cnt - d0), 128'd0);
        chk("vf_busy", oBusy, 1'b1);
        finish_hash("vf", model_result(), 1'b1);

        // T6: restart during MUL with a new key, aborted hash never completes
        start({$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b1, 1'b0);
        d0 = done_cnt;
        start({$urandom, $urandom, $urandom, $urandom});
        repeat (5) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b0);
        finish_hash("abort", model_result(), 1'b0);
        @(negedge clk);
        chk("abort_one_done", 128'(done_cnt - d0), 128'd1);

        // Async reset in ACCEPT clears outputs before the next clock edge
        start({$urandom, $urandom, $urandom, $urandom});
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0, 1'b0);
        send({$urandom, $urandom, $urandom, $urandom}, 16, 1'b1, 1'b0);
        while (!oBlkReady) @(negedge clk);
        d0 = done_cnt;
        #2 iRst = 1'b1;
        #1;
        chk("arst_ghash", oGhash, 128'd0);
        chk("arst_busy", oBusy, 1'b0);
        chk("arst_ready", oBlkReady, 1'b0);
        chk("arst_err", oErr, 1'b0);
        chk("arst_done", oDone, 1'b0);
        repeat (3) @(negedge clk);
        iRst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_done", 128'(done_cnt - d0), 128'd0);
        chk("arst_idle_ready", oBlkReady, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
